// File: rtl/trdb_output_arbiter.sv
// Trace debugger output arbiter: shares the uDMA word port between the trace
// stream and software-dump words (header + data pairs), with burst-limited priority.
module trdb_output_arbiter #(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     DUMP_DEPTH  = 4,
    parameter int unsigned     BURST_LIMIT = 8,
    parameter logic [XLEN-1:0] SW_HEADER   = 32'h5744_0001
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [XLEN-1:0] trace_word_i,
    input  logic            trace_valid_i,
    output logic            trace_ready_o,
    input  logic [XLEN-1:0] dump_word_i,
    input  logic            dump_valid_i,
    output logic            dump_full_o,
    output logic            dump_overflow_o,
    input  logic            clr_overflow_i,
    input  logic            flush_i,
    output logic            flush_done_o,
    output logic [XLEN-1:0] word_o,
    output logic            word_valid_o,
    input  logic            stall_i
);

    localparam int unsigned     AW      = (DUMP_DEPTH > 1) ? $clog2(DUMP_DEPTH) : 1;
    localparam int unsigned     CW      = AW + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(DUMP_DEPTH);
    localparam logic [7:0]      LIMIT_C = 8'(BURST_LIMIT);

    typedef enum logic {
        ST_ARB,
        ST_DUMP_DATA
    } state_t;

    logic [XLEN-1:0] r_mem [DUMP_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    state_t          r_state;
    logic [7:0]      r_burst_cnt;
    logic [XLEN-1:0] r_word;
    logic            r_word_valid;
    logic            r_overflow;
    logic            r_flush_pending;
    logic            r_flush_done;

    logic w_load_en;
    logic w_empty;
    logic w_full;
    logic w_take_dump;
    logic w_trace_acc;
    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_flush_cond;

    always_comb begin
        w_load_en    = !r_word_valid || !stall_i;
        w_empty      = (r_count == '0);
        w_full       = (r_count == DEPTH_C);
        // Dump wins when trace is idle or trace has used up its burst allowance.
        w_take_dump  = !w_empty && (!trace_valid_i || (r_burst_cnt == LIMIT_C));
        w_trace_acc  = (r_state == ST_ARB) && w_load_en && trace_valid_i && !w_take_dump;
        w_pop        = (r_state == ST_DUMP_DATA) && w_load_en;
        w_push       = dump_valid_i && (!w_full || w_pop);
        w_drop       = dump_valid_i && !w_push;
        w_flush_cond = r_flush_pending && (r_state == ST_ARB) && w_empty &&
                       !r_word_valid && !trace_valid_i;
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= dump_word_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= ST_ARB;
            r_word       <= '0;
            r_word_valid <= 1'b0;
            r_burst_cnt  <= '0;
        end else begin
            if (w_load_en) begin
                case (r_state)
                    ST_ARB: begin
                        if (w_take_dump) begin
                            r_word       <= SW_HEADER;
                            r_word_valid <= 1'b1;
                            r_state      <= ST_DUMP_DATA;
                        end else if (trace_valid_i) begin
                            r_word       <= trace_word_i;
                            r_word_valid <= 1'b1;
                        end else begin
                            r_word_valid <= 1'b0;
                        end
                    end
                    ST_DUMP_DATA: begin
                        r_word       <= r_mem[r_rd_ptr];
                        r_word_valid <= 1'b1;
                        r_state      <= ST_ARB;
                    end
                    default: r_state <= ST_ARB;
                endcase
            end
            if (w_pop || w_empty) begin
                r_burst_cnt <= '0;
            end else if (w_trace_acc && (r_burst_cnt != LIMIT_C)) begin
                r_burst_cnt <= r_burst_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_overflow      <= 1'b0;
            r_flush_pending <= 1'b0;
            r_flush_done    <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_overflow_i) begin
                r_overflow <= 1'b0;
            end
            r_flush_done <= w_flush_cond;
            if (w_flush_cond) begin
                r_flush_pending <= 1'b0;
            end else if (flush_i) begin
                r_flush_pending <= 1'b1;
            end
        end
    end

    assign trace_ready_o   = w_trace_acc;
    assign dump_full_o     = w_full;
    assign dump_overflow_o = r_overflow;
    assign flush_done_o    = r_flush_done;
    assign word_o          = r_word;
    assign word_valid_o    = r_word_valid;

endmodule

// File: tb/tb_trdb_output_arbiter.sv
// Self-checking bench for trdb_output_arbiter: directed vectors, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_trdb_output_arbiter;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LIMIT = 8;
    localparam logic [31:0] HDR   = 32'h5744_0001;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] trace_word_i;
    logic        trace_valid_i;
    logic        trace_ready_o;
    logic [31:0] dump_word_i;
    logic        dump_valid_i;
    logic        dump_full_o;
    logic        dump_overflow_o;
    logic        clr_overflow_i;
    logic        flush_i;
    logic        flush_done_o;
    logic [31:0] word_o;
    logic        word_valid_o;
    logic        stall_i;

    int n_chk  = 0;
    int n_fail = 0;

    trdb_output_arbiter #(
        .XLEN        (32),
        .DUMP_DEPTH  (DEPTH),
        .BURST_LIMIT (LIMIT),
        .SW_HEADER   (HDR)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .trace_word_i    (trace_word_i),
        .trace_valid_i   (trace_valid_i),
        .trace_ready_o   (trace_ready_o),
        .dump_word_i     (dump_word_i),
        .dump_valid_i    (dump_valid_i),
        .dump_full_o     (dump_full_o),
        .dump_overflow_o (dump_overflow_o),
        .clr_overflow_i  (clr_overflow_i),
        .flush_i         (flush_i),
        .flush_done_o    (flush_done_o),
        .word_o          (word_o),
        .word_valid_o    (word_valid_o),
        .stall_i         (stall_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic nxt();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drv(input logic tv, input logic [31:0] tw, input logic dv,
                       input logic [31:0] dw, input logic st);
        trace_valid_i  = tv;
        trace_word_i   = tw;
        dump_valid_i   = dv;
        dump_word_i    = dw;
        stall_i        = st;
        flush_i        = 1'b0;
        clr_overflow_i = 1'b0;
    endtask

    // Reference model: the dump FIFO is a queue, the output port a word/valid pair,
    // and "data owed after a header" a flag. Checked and advanced once per cycle.
    logic [31:0] m_q[$];
    logic [31:0] m_word;
    bit          m_valid, m_data_owed, m_ovf, m_fpend, m_done;
    int          m_burst;

    always @(negedge clk_i) begin : model
        int sz;
        bit ld, take_hdr, e_ready, popped, cond;
        if (!rst_ni) begin
            m_q.delete();
            m_word = '0; m_valid = 0; m_data_owed = 0; m_ovf = 0;
            m_fpend = 0; m_done = 0; m_burst = 0;
        end else begin
            sz       = m_q.size();
            ld       = !m_valid || !stall_i;
            take_hdr = !m_data_owed && sz > 0 && (!trace_valid_i || m_burst == LIMIT);
            e_ready  = ld && !m_data_owed && !take_hdr && trace_valid_i;
            chk("model_valid", 32'(word_valid_o), 32'(m_valid));
            if (m_valid) chk("model_word", word_o, m_word);
            chk("model_ready", 32'(trace_ready_o), 32'(e_ready));
            chk("model_full", 32'(dump_full_o), 32'(sz == DEPTH));
            chk("model_ovf", 32'(dump_overflow_o), 32'(m_ovf));
            chk("model_done", 32'(flush_done_o), 32'(m_done));

            cond   = m_fpend && !m_data_owed && sz == 0 && !m_valid && !trace_valid_i;
            m_done = cond;
            if (cond) m_fpend = 0;
            else if (flush_i) m_fpend = 1;

            popped = 0;
            if (ld) begin
                if (m_data_owed) begin
                    m_word = m_q.pop_front(); m_valid = 1; m_data_owed = 0;
                    popped = 1; m_burst = 0;
                end else if (take_hdr) begin
                    m_word = HDR; m_valid = 1; m_data_owed = 1;
                end else if (trace_valid_i) begin
                    m_word = trace_word_i; m_valid = 1;
                    if (sz > 0 && m_burst < LIMIT) m_burst++;
                end else begin
                    m_valid = 0;
                end
            end
            if (sz == 0) m_burst = 0;

            if (dump_valid_i) begin
                if (sz < DEPTH || popped) m_q.push_back(dump_word_i);
                else m_ovf = 1;
            end else if (clr_overflow_i) begin
                m_ovf = 0;
            end
            if (dump_valid_i && !(sz < DEPTH || popped)) m_ovf = 1;
            else if (dump_valid_i && clr_overflow_i) m_ovf = 0;
        end
    end

    typedef struct {
        logic        tv;
        logic [31:0] tw;
        logic        dv;
        logic [31:0] dw;
        logic        st;
        logic        e_rdy;
        logic        e_vld;
        logic [31:0] e_word;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] seen[$];
        int n, w, hdrs, dones, ndata, prev_vld;

        tbl[0] = '{1'b0, 32'h0,  1'b1, 32'hCAFE_0000, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[1] = '{1'b0, 32'h0,  1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0};
        tbl[2] = '{1'b0, 32'h0,  1'b0, 32'h0,         1'b0, 1'b0, 1'b1, HDR};
        tbl[3] = '{1'b0, 32'h0,  1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'hCAFE_0000};
        tbl[4] = '{1'b1, 32'hA1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0};
        tbl[5] = '{1'b1, 32'hA2, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'hA1};
        tbl[6] = '{1'b1, 32'hA2, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'hA1};
        tbl[7] = '{1'b0, 32'h0,  1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'hA2};
        tbl[8] = '{1'b0, 32'h0,  1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0};
        tbl[9] = '{1'b0, 32'h0,  1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0};

        rst_ni = 1'b0;
        drv(0, 0, 0, 0, 0);
        @(negedge clk_i);
        chk("rst_word", word_o, 32'h0);
        chk("rst_valid", 32'(word_valid_o), 0);
        chk("rst_done", 32'(flush_done_o), 0);
        chk("rst_ovf", 32'(dump_overflow_o), 0);
        chk("rst_full", 32'(dump_full_o), 0);
        chk("rst_ready", 32'(trace_ready_o), 0);
        nxt();
        rst_ni = 1'b1;
        nxt();

        // Dump on an idle path, then short trace traffic with one stalled cycle.
        for (int i = 0; i < 10; i++) begin
            drv(tbl[i].tv, tbl[i].tw, tbl[i].dv, tbl[i].dw, tbl[i].st);
            @(negedge clk_i);
            chk($sformatf("tbl%0d_ready", i), 32'(trace_ready_o), 32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_valid", i), 32'(word_valid_o), 32'(tbl[i].e_vld));
            if (tbl[i].e_vld) chk($sformatf("tbl%0d_word", i), word_o, tbl[i].e_word);
            nxt();
        end

        // Trace only: 1..10 back to back.
        for (int i = 1; i <= 11; i++) begin
            if (i <= 10) drv(1, 32'(i), 0, 0, 0);
            else drv(0, 0, 0, 0, 0);
            @(negedge clk_i);
            if (i <= 10) chk("trace_ready", 32'(trace_ready_o), 1);
            if (i > 1) chk("trace_word", word_o, 32'(i - 1));
            nxt();
        end
        drv(0, 0, 0, 0, 0); nxt();

        // Starvation limit: trace held valid, one dump pushed.
        drv(1, 32'h100, 1, 32'hDD00_00DD, 0);
        @(negedge clk_i);
        chk("starve_first_ready", 32'(trace_ready_o), 1);
        nxt();
        n = 0;
        for (int i = 1; i < 20; i++) begin
            drv(1, 32'h100 + 32'(i), 0, 0, 0);
            @(negedge clk_i);
            if (!trace_ready_o) break;
            n++;
            nxt();
        end
        chk("starve_burst_len", 32'(n), 32'(LIMIT));
        nxt();
        @(negedge clk_i);
        chk("starve_hdr", word_o, HDR);
        chk("starve_hdr_ready", 32'(trace_ready_o), 0);
        nxt();
        @(negedge clk_i);
        chk("starve_data", word_o, 32'hDD00_00DD);
        chk("starve_resume", 32'(trace_ready_o), 1);
        nxt();
        drv(0, 0, 0, 0, 0); nxt(); nxt(); nxt();

        // Overflow: stall with a valid word, push DEPTH+1 dumps.
        drv(1, 32'h7, 0, 0, 0); nxt();
        for (int k = 0; k < 5; k++) begin
            drv(0, 0, 1, 32'hE0 + 32'(k), 1);
            @(negedge clk_i);
            chk("ovf_hold_word", word_o, 32'h7);
            chk("ovf_full", 32'(dump_full_o), 32'(k == 4));
            chk("ovf_flag_early", 32'(dump_overflow_o), 0);
            nxt();
        end
        drv(0, 0, 0, 0, 1);
        @(negedge clk_i);
        chk("ovf_flag", 32'(dump_overflow_o), 1);
        nxt();
        drv(0, 0, 0, 0, 0);
        seen.delete();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (word_valid_o) seen.push_back(word_o);
            nxt();
        end
        chk("ovf_out_count", 32'(seen.size()), 9);
        hdrs = 0;
        for (int i = 1; i < 9 && i < seen.size(); i++) begin
            if (i % 2 == 1) begin
                chk("ovf_out_hdr", seen[i], HDR);
                hdrs++;
            end else begin
                chk("ovf_out_data", seen[i], 32'hE0 + 32'(i / 2 - 1));
            end
        end
        chk("ovf_hdr_count", 32'(hdrs), 4);
        clr_overflow_i = 1'b1;
        @(negedge clk_i);
        chk("ovf_before_clr", 32'(dump_overflow_o), 1);
        nxt();
        clr_overflow_i = 1'b0;
        @(negedge clk_i);
        chk("ovf_cleared", 32'(dump_overflow_o), 0);
        nxt();

        // Stall hold mid-stream.
        w = 0;
        for (int i = 0; i < 9; i++) begin
            drv(1, 32'h200 + 32'(w), 0, 0, (i >= 3 && i <= 5));
            @(negedge clk_i);
            if (i >= 3 && i <= 5) begin
                chk("stall_ready", 32'(trace_ready_o), 0);
                chk("stall_valid", 32'(word_valid_o), 1);
                chk("stall_word", word_o, 32'h202);
            end
            if (trace_ready_o) w++;
            nxt();
        end
        chk("stall_accepted", 32'(w), 6);
        drv(0, 0, 0, 0, 0); nxt(); nxt();

        // Flush with two dumps queued behind a stall; second flush while pending.
        drv(1, 32'h11, 0, 0, 0); nxt();
        drv(0, 0, 1, 32'hF0, 1); nxt();
        drv(0, 0, 1, 32'hF1, 1); flush_i = 1'b1; nxt();
        drv(0, 0, 0, 0, 0); flush_i = 1'b1;
        dones = 0; ndata = 0; prev_vld = 1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_i);
            if (flush_done_o) begin
                dones++;
                chk("flush_after_data", 32'(ndata), 2);
                chk("flush_prev_idle", 32'(prev_vld), 0);
            end
            if (word_valid_o && (word_o == 32'hF0 || word_o == 32'hF1)) ndata++;
            prev_vld = int'(word_valid_o);
            nxt();
            flush_i = 1'b0;
        end
        chk("flush_pulses", 32'(dones), 1);

        // Randomized traffic with one mid-run reset; the model checks every cycle.
        for (int i = 0; i < 2000; i++) begin
            drv($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 99) < 20, $urandom,
                $urandom_range(0, 9) < 4);
            flush_i        = $urandom_range(0, 99) < 3;
            clr_overflow_i = $urandom_range(0, 99) < 5;
            if (i == 1000) rst_ni = 1'b0;
            if (i == 1002) rst_ni = 1'b1;
            nxt();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/trdb_output_arbiter.md
# trdb_output_arbiter

Output-side controller for the trace debugger. It shares the single 32-bit word port toward the uDMA between two requesters: the aligned trace packet stream and software-dump words written over APB. Dump words are buffered in a small FIFO and emitted as a header/data word pair. Trace words have priority, but a burst limit prevents dumps from being starved. The block also sequences stream flushes and reports when the output path is empty.

## Interface
- XLEN, 32: word width; only 32 is supported.
- DUMP_DEPTH, 4: dump FIFO entries; must be a power of two and at least 2.
- BURST_LIMIT, 8: maximum number of consecutive trace words that may be emitted while a dump is pending; range 1..255.
- SW_HEADER, 32'h5744_0001: marker word emitted immediately before each dump data word.

- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- trace_word_i  in  XLEN  word from the stream aligner.
- trace_valid_i  in  1  trace_word_i is valid.
- trace_ready_o  out  1  trace word accepted this cycle; combinational.
- dump_word_i  in  XLEN  software dump data from the register file.
- dump_valid_i  in  1  single-cycle push request.
- dump_full_o  out  1  dump FIFO is full.
- dump_overflow_o  out  1  sticky flag: a dump word was dropped.
- clr_overflow_i  in  1  clears dump_overflow_o.
- flush_i  in  1  single-cycle request to drain all pending output.
- flush_done_o  out  1  single-cycle pulse: the drain has completed.
- word_o  out  XLEN  output word; registered.
- word_valid_o  out  1  word_o is valid; registered.
- stall_i  in  1  downstream back-pressure.

## Operation
- **Output register.** It holds word_o and word_valid_o.
  - load_en = !word_valid_o || !stall_i.
  - While stall_i=1 and word_valid_o=1, word_o and word_valid_o must stay unchanged.
  - If load_en=1 and nothing is loaded, word_valid_o goes to 0 on the next cycle.
- **Dump FIFO.** DUMP_DEPTH entries, with a count of width clog2(DUMP_DEPTH)+1.
  - A push with dump_valid_i=1 is accepted when the FIFO is not full, or when a pop occurs in the same cycle.
  - Otherwise the word is dropped and dump_overflow_o is set on the next edge.
  - If clr_overflow_i and a drop occur in the same cycle, the set wins.
  - Pointers wrap modulo DUMP_DEPTH.
- **FSM states: ARB and DUMP_DATA.** Reset state is ARB.
  - ARB with load_en=1, dump branch: if the FIFO is non-empty and (trace_valid_i=0 or burst_cnt==BURST_LIMIT), load SW_HEADER and go to DUMP_DATA. trace_ready_o=0.
  - ARB with load_en=1, trace branch: otherwise, if trace_valid_i=1, load trace_word_i and assert trace_ready_o. burst_cnt increments only while the FIFO is non-empty, saturating at BURST_LIMIT.
  - DUMP_DATA with load_en=1: load the FIFO head, pop it, clear burst_cnt, and go to ARB. trace_ready_o=0 in this state.
  - With load_en=0 in any state, the FSM holds, nothing is loaded, and trace_ready_o=0.
  - A header is always followed directly by its data word; no trace word is emitted between them.
  - burst_cnt is 8 bits and is also cleared whenever the FIFO is empty.
- **Flush.**
  - flush_i sets flush_pending.
  - When flush_pending=1, state=ARB, the FIFO is empty, word_valid_o=0 and trace_valid_i=0, the block pulses flush_done_o for one cycle and clears flush_pending.
  - flush_i while flush_pending=1 is ignored.
  - Trace and dump traffic is still served during a flush.
- **Reset.** Asserting rst_ni mid-operation discards the FIFO contents, any pending header or data, and any pending flush.

## Timing
- Reset values:
  - word_o = 0, word_valid_o = 0, flush_done_o = 0, dump_overflow_o = 0.
  - dump_full_o = 0, trace_ready_o = 0 (no trace valid).
  - Internal: state ARB, burst_cnt = 0.
- Trace latency: a trace word accepted in cycle t appears on word_o in cycle t+1.
- Dump latency with an idle path:
  - dump_valid_i in cycle t;
  - SW_HEADER on word_o in cycle t+2;
  - data word in cycle t+3.
- dump_full_o is registered-derived: it reflects the count after the previous edge.
- flush_done_o is asserted one cycle after its conditions are met at a clock edge. The conditions are sampled combinationally and the pulse is registered.
- Throughput is one word per cycle when stall_i=0.

## Test plan
- **Trace only.** Drive trace words 1..10 back-to-back with stall_i=0 → word_o=1..10 on consecutive cycles, each one cycle after its ready; trace_ready_o=1 throughout.
- **Dump while idle.** Push 0xCAFE0000 → word_o=0x57440001, then 0xCAFE0000, on consecutive cycles; the FIFO is then empty.
- **Starvation limit.** Hold trace_valid_i=1 continuously, BURST_LIMIT=8, and push one dump → exactly 8 trace words, then header and dump data, then trace resumes; trace_ready_o=0 for those 2 cycles.
- **Overflow.** Hold stall_i=1 with word_valid_o=1 and push 5 dumps with DEPTH=4 → dump_full_o=1 after the 4th push, dump_overflow_o=1 after the 5th. Release the stall → exactly 4 header/data pairs emerge. clr_overflow_i → flag returns to 0.
- **Stall hold.** Assert stall_i for 3 cycles mid-stream → word_o and word_valid_o stay constant; no trace_ready_o and no FIFO pop during the stall.
- **Flush.** Pulse flush_i with 2 dumps queued and stall_i=1 for 2 cycles → flush_done_o pulses once, only after the last data word is accepted and word_valid_o=0. A second flush_i while pending → no extra pulse.
